// File: rtl/wave_seq_ctrl_if.sv
// Control/status bundle between a waveform sequencer controller and its host + address counter.
// Optional pause input is present only when WAVE_SEQ_CTRL_PAUSE_EN is defined.
interface wave_seq_ctrl_if #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
);
    logic                   start;
    logic                   stop;
    logic [DIV_WIDTH-1:0]   div;
    logic [BURST_WIDTH-1:0] burst;
    logic                   cnt_tc;
`ifdef WAVE_SEQ_CTRL_PAUSE_EN
    logic                   pause;
`endif
    logic                   cnt_en;
    logic                   cnt_rst;
    logic                   busy;
    logic                   done;
    logic [BURST_WIDTH-1:0] periods;

    modport slave (
        input  start, stop, div, burst, cnt_tc,
`ifdef WAVE_SEQ_CTRL_PAUSE_EN
        input  pause,
`endif
        output cnt_en, cnt_rst, busy, done, periods
    );

    modport master (
        output start, stop, div, burst, cnt_tc,
`ifdef WAVE_SEQ_CTRL_PAUSE_EN
        output pause,
`endif
        input  cnt_en, cnt_rst, busy, done, periods
    );
endinterface

// File: rtl/wave_seq_ctrl.sv
// Waveform sequencer controller: prescaled address-counter strobes, burst/continuous play, graceful stop.
// Define WAVE_SEQ_CTRL_PAUSE_EN to add a pause input that freezes the prescaler while in RUN.
module wave_seq_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    wave_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DIV_WIDTH-1:0]   presc_q, presc_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] periods_q, periods_d;
    logic                   stop_pend_q, stop_pend_d;

    logic                   hold;
    logic                   strobe;
    logic                   period_end;
    logic                   burst_hit;
    logic [BURST_WIDTH-1:0] periods_inc;

`ifdef WAVE_SEQ_CTRL_PAUSE_EN
    assign hold = bus.pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            presc_q     <= '0;
            burst_q     <= '0;
            periods_q   <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            presc_q     <= presc_d;
            burst_q     <= burst_d;
            periods_q   <= periods_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        strobe      = (state_q == RUN) && (presc_q == '0) && !hold;
        period_end  = strobe && bus.cnt_tc;
        periods_inc = (periods_q == '1) ? periods_q : periods_q + BURST_WIDTH'(1);
        burst_hit   = (burst_q != '0) && (periods_inc == burst_q);

        state_d     = state_q;
        div_d       = div_q;
        presc_d     = presc_q;
        burst_d     = burst_q;
        periods_d   = periods_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = ARM;
                    div_d       = bus.div;
                    burst_d     = bus.burst;
                    periods_d   = '0;
                    stop_pend_d = 1'b0;
                end
            end
            ARM: begin
                presc_d = div_q;
                state_d = RUN;
            end
            RUN: begin
                if (!hold) begin
                    presc_d = (presc_q == '0) ? div_q : presc_q - DIV_WIDTH'(1);
                end
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                // stop_pend_q (not stop) gates termination, so a stop landing on a period end waits one more period
                if (period_end) begin
                    periods_d = periods_inc;
                    if (burst_hit || stop_pend_q) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cnt_en  = strobe;
    assign bus.cnt_rst = (state_q != IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == FINISH);
    assign bus.periods = periods_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Directed bench for wave_seq_ctrl; cnt_tc comes from a 2-bit address counter (tc every 4th enable)
// or is forced high to make every strobe a period end.
module tb_wave_seq_ctrl;
    localparam int DW = 16;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wave_seq_ctrl_if #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

    wave_seq_ctrl #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [1:0] addr_q = 2'd0;
    logic       tc_force = 1'b0;
    always @(posedge clk) begin
        if (!bus.cnt_rst)    addr_q <= 2'd0;
        else if (bus.cnt_en) addr_q <= addr_q + 2'd1;
    end
    assign bus.cnt_tc = tc_force | (addr_q == 2'd3);

    int n_chk = 0;
    int n_pass = 0;
    int ncyc = 0;
    int strobes, dones, arm_cyc, first_cyc, last_cyc, min_gap, max_gap, viol;
    logic busy_prev = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic clr_stats();
        strobes = 0; dones = 0; arm_cyc = -1; first_cyc = -1; last_cyc = -1;
        min_gap = 1000000; max_gap = 0; viol = 0;
    endtask

    task automatic tick();
        int gap;
        @(negedge clk);
        ncyc++;
        if (bus.busy && !busy_prev) arm_cyc = ncyc;
        if (bus.cnt_en) begin
            strobes++;
            if (first_cyc < 0) first_cyc = ncyc;
            else begin
                gap = ncyc - last_cyc;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end
            last_cyc = ncyc;
        end
        if (bus.done) dones++;
        if (bus.busy && !bus.cnt_rst) viol++;
        if (bus.done && bus.cnt_en) viol++;
        if (!bus.busy && (bus.cnt_en || bus.cnt_rst || bus.done)) viol++;
        busy_prev = bus.busy;
    endtask

    task automatic start_run(input logic [DW-1:0] d, input logic [BW-1:0] b);
        clr_stats();
        bus.div = d; bus.burst = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (dones == 0 && n < maxc) begin tick(); n++; end
        chk({tag, "_done_timeout"}, (dones == 0), 0);
    endtask

    task automatic wait_strobes(input string tag, input int k, input int maxc);
        int n = 0;
        while (strobes < k && n < maxc) begin tick(); n++; end
        chk({tag, "_strobe_timeout"}, (strobes < k), 0);
    endtask

    task automatic post_checks(input string tag);
        repeat (3) tick();
        chk({tag, "_idle_busy"}, bus.busy, 0);
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_ctrl_viol"}, viol, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.div = '0; bus.burst = '0;
`ifdef WAVE_SEQ_CTRL_PAUSE_EN
        bus.pause = 1'b0;
`endif
        clr_stats();
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt_en", bus.cnt_en, 0);
        chk("rst_cnt_rst", bus.cnt_rst, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_periods", bus.periods, 0);
        rst = 1'b1;
        repeat (2) tick();

        // div=3 burst=2: strobe every 4 clocks, 8 strobes, 2 periods
        start_run(16'd3, 8'd2);
        wait_done("t1", 100);
        chk("t1_periods", bus.periods, 2);
        chk("t1_strobes", strobes, 8);
        chk("t1_first_lat", first_cyc - arm_cyc, 4);
        chk("t1_min_gap", min_gap, 4);
        chk("t1_max_gap", max_gap, 4);
        post_checks("t1");
        chk("t1_periods_held", bus.periods, 2);

        // continuous, stop after 5th strobe finishes at the next period end
        start_run(16'd0, 8'd0);
        wait_strobes("t2", 5, 50);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_done("t2", 50);
        chk("t2_periods", bus.periods, 2);
        chk("t2_strobes", strobes, 8);
        chk("t2_first_lat", first_cyc - arm_cyc, 1);
        chk("t2_max_gap", max_gap, 1);
        post_checks("t2");

        // stop raised in the very cycle of a period end: that end does not terminate
        start_run(16'd0, 8'd0);
        wait_strobes("t3", 4, 50);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_done("t3", 50);
        chk("t3_strobes", strobes, 8);
        chk("t3_periods", bus.periods, 2);
        post_checks("t3");

        // start re-pulsed and div/burst changed mid-run are ignored
        start_run(16'd1, 8'd1);
        wait_strobes("t4", 1, 20);
        bus.start = 1'b1; bus.div = 16'd7; bus.burst = 8'd0;
        tick();
        bus.start = 1'b0;
        wait_done("t4", 50);
        chk("t4_strobes", strobes, 4);
        chk("t4_periods", bus.periods, 1);
        chk("t4_first_lat", first_cyc - arm_cyc, 2);
        chk("t4_min_gap", min_gap, 2);
        chk("t4_max_gap", max_gap, 2);
        post_checks("t4");

`ifdef WAVE_SEQ_CTRL_PAUSE_EN
        // pause for 10 cycles one cycle after the 2nd strobe stretches that gap from 3 to 13
        begin
            int s;
            start_run(16'd2, 8'd1);
            wait_strobes("t5", 2, 30);
            tick();
            s = strobes;
            bus.pause = 1'b1;
            repeat (10) tick();
            chk("t5_pause_strobes", strobes - s, 0);
            chk("t5_pause_busy", bus.busy, 1);
            bus.pause = 1'b0;
            wait_done("t5", 50);
            chk("t5_strobes", strobes, 4);
            chk("t5_min_gap", min_gap, 3);
            chk("t5_max_gap", max_gap, 13);
            chk("t5_periods", bus.periods, 1);
            post_checks("t5");
        end
`endif

        // every strobe is a period end: burst=255 completes after 255 strobes
        tc_force = 1'b1;
        start_run(16'd0, 8'd255);
        wait_done("t6", 400);
        chk("t6_periods", bus.periods, 255);
        chk("t6_strobes", strobes, 255);
        post_checks("t6");

        // continuous with forced tc: periods saturates at 255, then graceful stop
        start_run(16'd0, 8'd0);
        repeat (300) tick();
        chk("t7_sat_periods", bus.periods, 255);
        chk("t7_still_busy", bus.busy, 1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_done("t7", 20);
        chk("t7_periods", bus.periods, 255);
        post_checks("t7");
        tc_force = 1'b0;

        // asynchronous reset mid-run aborts without a done pulse
        start_run(16'd3, 8'd0);
        wait_strobes("t8", 5, 100);
        #2 rst = 1'b0;
        #1;
        chk("t8_busy", bus.busy, 0);
        chk("t8_cnt_rst", bus.cnt_rst, 0);
        chk("t8_cnt_en", bus.cnt_en, 0);
        chk("t8_periods", bus.periods, 0);
        chk("t8_done", bus.done, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("t8_done_count", dones, 0);
        chk("t8_idle_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wave_seq_ctrl.md
WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, sample-period prescaler width.
REQ-002 SHALL have parameter BURST_WIDTH, default 8, waveform-period burst counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, start request, sampled in IDLE only.
REQ-006 SHALL have port stop, input, 1, graceful stop request, sampled in RUN.
REQ-007 SHALL have port div, input, DIV_WIDTH, sample period minus 1 in clocks, latched on start.
REQ-008 SHALL have port burst, input, BURST_WIDTH, waveform periods to play, 0 = continuous, latched on start.
REQ-009 SHALL have port cnt_tc, input, 1, terminal count from the address counter.
REQ-010 SHALL have port cnt_en, output, 1, address-counter enable strobe.
REQ-011 SHALL have port cnt_rst, output, 1, active-low synchronous clear to the address counter.
REQ-012 SHALL have port busy, output, 1, high in ARM, RUN, FINISH.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port periods, output, BURST_WIDTH, completed waveform periods since last start.

Function
REQ-015 SHALL implement FSM states IDLE, ARM, RUN, FINISH; all outputs decoded from registered state.
REQ-016 IDLE: cnt_rst=0, cnt_en=0, busy=0; start=1 -> ARM, latch div/burst, clear periods and stop_pending.
REQ-017 ARM: exactly one cycle; cnt_rst=1, cnt_en=0, prescaler loaded with latched div; -> RUN.
REQ-018 RUN: cnt_rst=1; prescaler decrements each cycle; at prescaler==0, cnt_en=1 for that cycle and prescaler reloads latched div.
REQ-019 First cnt_en SHALL occur div+1 cycles after the ARM cycle; div=0 gives cnt_en every RUN cycle.
REQ-020 Period end = cnt_en && cnt_tc in same cycle; periods increments, saturating at 2**BURST_WIDTH-1.
REQ-021 If burst!=0 and a period end makes periods equal burst -> FINISH.
REQ-022 stop=1 in RUN SHALL set stop_pending; next period end -> FINISH; stop and burst completion on the same period end give one FINISH.
REQ-023 Period end coinciding with the stop-asserting cycle SHALL NOT by itself terminate; termination is at the following period end.
REQ-024 FINISH: one cycle, done=1, cnt_en=0, cnt_rst=1; -> IDLE.
REQ-025 start outside IDLE SHALL be ignored; stop outside RUN SHALL be ignored.
REQ-026 div/burst changes after latch SHALL NOT affect the active run.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, prescaler=0, periods=0, stop_pending=0, latched div/burst=0.
REQ-028 During and after reset: cnt_en=0, cnt_rst=0, busy=0, done=0; mid-run reset aborts without done pulse.

Configuration
REQ-029 Macro WAVE_SEQ_CTRL_PAUSE_EN, when defined, SHALL add input pause (1 bit).
REQ-030 With macro: pause=1 in RUN freezes prescaler and forces cnt_en=0, state and periods held; release resumes the count without reload.
REQ-031 Without macro: no pause port; RUN behaves per REQ-018 unconditionally.

Verification (bench drives cnt_tc from a 2-bit counter instance: tc every 4th enable)
REQ-032 Reset: rst=0 mid-RUN -> immediately IDLE, cnt_rst=0, periods=0, no done pulse.
REQ-033 div=3, burst=2, start pulse -> cnt_en every 4 clocks, 8 strobes total, periods=2, done one cycle, then IDLE.
REQ-034 div=0, burst=0, stop asserted after 5th strobe -> continues to 8th strobe, periods=2, done, IDLE.
REQ-035 div=1, burst=1, start re-pulsed in RUN and div changed to 7 -> ignored, strobes every 2 clocks, 4 strobes, done.
REQ-036 With WAVE_SEQ_CTRL_PAUSE_EN, div=2, burst=1, pause 10 cycles after 2nd strobe -> no strobes during pause, strobe spacing 3 otherwise, 4 strobes, done.
REQ-037 burst=255 forced via 1-bit-wide tc held high, div=0 -> periods reaches 255, done fires once.
